// File: rtl/LAG_pkg.sv
// LAG_pkg: shared router constants, requester state enum and slot activity mask.
package LAG_pkg;
  localparam int IN = 0;
  localparam int OUT = 1;
  localparam int NUMGROUPS = 5;
  localparam int MAX_GROUPSIZE = 4;
  localparam int NSLOTS = NUMGROUPS * MAX_GROUPSIZE;
  typedef enum logic {IDLE, LOCKED} req_state_t;
  typedef int links_t [NUMGROUPS][2];
  function automatic logic [NSLOTS-1:0] active_mask(input links_t l);
    logic [NSLOTS-1:0] m;
    m = '0;
    for (int g = 0; g < NUMGROUPS; g++)
      for (int s = 0; s < MAX_GROUPSIZE; s++)
        m[g*MAX_GROUPSIZE+s] = s < l[g][IN];
    return m;
  endfunction
endpackage

// File: rtl/lag_credit_counter.sv
// lag_credit_counter: downstream buffer credit count with saturating overflow detect.
module lag_credit_counter #(
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         consume,
  input  logic                         credit_in,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow
);
  localparam int W = $clog2(depth + 1);
  assign overflow = credit_in && !consume && count == W'(depth);
  always_ff @(posedge clk)
    if (!rst_n) count <= W'(depth);
    else if (consume && !credit_in) count <= count - W'(1);
    else if (credit_in && !consume && !overflow) count <= count + W'(1);
endmodule

// File: rtl/lag_switch_requester.sv
// lag_switch_requester: drives arbiter requests, holds wormhole ownership and tracks credits.
module lag_switch_requester
  import LAG_pkg::*;
#(
  parameter int     numgroups     = NUMGROUPS,
  parameter int     max_groupsize = MAX_GROUPSIZE,
  parameter links_t links         = '{default: 2},
  parameter int     buf_depth     = 4,
  localparam int    N             = numgroups * max_groupsize,
  localparam int    CW            = $clog2(buf_depth + 1),
  localparam int    OW            = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  head_valid,
  input  logic [N-1:0]  head_tail,
  output logic [N-1:0]  request,
  input  logic [N-1:0]  grant,
  output logic          success,
  output logic [N-1:0]  pop,
  input  logic          credit_in,
  output logic [CW-1:0] credits,
  output logic          locked,
  output logic [1:0]    err
);
  localparam logic [N-1:0] ACTIVE = N'(active_mask(links));
  function automatic logic [OW-1:0] to_index(input logic [N-1:0] v);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) idx = OW'(i);
    return idx;
  endfunction
  req_state_t    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] gidx;
  logic          has_credit;
  logic          one_hot;
  logic          bad_grant;
  logic          xfer;
  logic          own_pop;
  logic          consume;
  logic          overflow;
  always_comb begin
    has_credit = credits != '0;
    request = (rst_n && state == IDLE && has_credit) ? head_valid & ACTIVE : '0;
    one_hot = grant != '0 && (grant & (grant - N'(1))) == '0;
    bad_grant = rst_n && grant != '0 && (state == LOCKED || !one_hot || (grant & ~request) != '0);
    xfer = rst_n && state == IDLE && grant != '0 && !bad_grant;
    own_pop = rst_n && state == LOCKED && head_valid[owner] && has_credit && !bad_grant;
    gidx = to_index(grant);
    success = xfer;
    pop = xfer ? grant : own_pop ? N'(1) << owner : '0;
    consume = |pop;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      err   <= '0;
    end else begin
      err <= err | {bad_grant, overflow};
      if (xfer && !head_tail[gidx]) begin
        state <= LOCKED;
        owner <= gidx;
      end else if (own_pop && head_tail[owner]) state <= IDLE;
    end
  assign locked = state == LOCKED;
  lag_credit_counter #(.depth(buf_depth)) u_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume   (consume),
    .credit_in (credit_in),
    .count     (credits),
    .overflow  (overflow)
  );
endmodule

// File: tb/tb_lag_switch_requester.sv
// tb_lag_switch_requester: directed vectors with a queued scoreboard checked on the falling edge.
module tb_lag_switch_requester;
  import LAG_pkg::*;
  localparam links_t TB_LINKS = '{'{4, 4}, '{2, 2}, '{2, 2}, '{2, 2}, '{2, 2}};
  typedef struct packed {
    logic [19:0] req;
    logic [19:0] pop;
    logic        suc;
    logic [2:0]  cred;
    logic        lk;
    logic [1:0]  er;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [19:0] head_valid = '0;
  logic [19:0] head_tail = '0;
  logic [19:0] grant = '0;
  logic        credit_in = 0;
  logic [19:0] request;
  logic [19:0] pop;
  logic        success;
  logic [2:0]  credits;
  logic        locked;
  logic [1:0]  err;
  exp_t        sb_q[$];
  int          id_q[$];
  exp_t        e;
  int          id;
  int          checks = 0;
  int          fails = 0;
  lag_switch_requester #(.links(TB_LINKS), .buf_depth(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .head_valid (head_valid),
    .head_tail  (head_tail),
    .request    (request),
    .grant      (grant),
    .success    (success),
    .pop        (pop),
    .credit_in  (credit_in),
    .credits    (credits),
    .locked     (locked),
    .err        (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input int n, input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step %0d %s: got %h expected %h", n, nm, act, exp);
    end
  endtask
  task automatic step(input int n, input logic rn, input logic [19:0] hv, input logic [19:0] ht,
                      input logic [19:0] g, input logic ci, input logic [19:0] x_req,
                      input logic [19:0] x_pop, input logic x_suc, input logic [2:0] x_cred,
                      input logic x_lk, input logic [1:0] x_er);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn;
    head_valid = hv;
    head_tail = ht;
    grant = g;
    credit_in = ci;
    x = '{req: x_req, pop: x_pop, suc: x_suc, cred: x_cred, lk: x_lk, er: x_er};
    sb_q.push_back(x);
    id_q.push_back(n);
  endtask
  initial forever begin
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      id = id_q.pop_front();
      chk(id, "request", request, e.req);
      chk(id, "pop", pop, e.pop);
      chk(id, "success", 20'(success), 20'(e.suc));
      chk(id, "credits", 20'(credits), 20'(e.cred));
      chk(id, "locked", 20'(locked), 20'(e.lk));
      chk(id, "err", 20'(err), 20'(e.er));
    end
  end
  initial begin
    @(posedge clk);
    step( 1, 0, 'h4,  'h4,  'h0,  0, 'h0,  'h0,  0, 4, 0, 0);
    step( 2, 1, 'h4,  'h4,  'h0,  0, 'h4,  'h0,  0, 4, 0, 0);
    step( 3, 1, 'h4,  'h4,  'h4,  0, 'h4,  'h4,  1, 4, 0, 0);
    step( 4, 1, 'h0,  'h0,  'h0,  1, 'h0,  'h0,  0, 3, 0, 0);
    step( 5, 1, 'h20, 'h0,  'h20, 0, 'h20, 'h20, 1, 4, 0, 0);
    step( 6, 1, 'h20, 'h0,  'h0,  0, 'h0,  'h20, 0, 3, 1, 0);
    step( 7, 1, 'h20, 'h20, 'h0,  0, 'h0,  'h20, 0, 2, 1, 0);
    step( 8, 1, 'h0,  'h0,  'h0,  0, 'h0,  'h0,  0, 1, 0, 0);
    step( 9, 1, 'h1,  'h0,  'h1,  0, 'h1,  'h1,  1, 1, 0, 0);
    step(10, 1, 'h3,  'h0,  'h0,  0, 'h0,  'h0,  0, 0, 1, 0);
    step(11, 1, 'h3,  'h0,  'h0,  1, 'h0,  'h0,  0, 0, 1, 0);
    step(12, 1, 'h2,  'h0,  'h0,  0, 'h0,  'h0,  0, 1, 1, 0);
    step(13, 1, 'h1,  'h1,  'h1,  0, 'h0,  'h0,  0, 1, 1, 0);
    step(14, 1, 'h1,  'h1,  'h0,  0, 'h0,  'h1,  0, 1, 1, 2);
    step(15, 1, 'h1,  'h1,  'h0,  1, 'h0,  'h0,  0, 0, 0, 2);
    step(16, 1, 'h1,  'h1,  'h0,  1, 'h1,  'h0,  0, 1, 0, 2);
    step(17, 1, 'h1,  'h1,  'h0,  1, 'h1,  'h0,  0, 2, 0, 2);
    step(18, 1, 'h1,  'h1,  'h0,  1, 'h1,  'h0,  0, 3, 0, 2);
    step(19, 1, 'h1,  'h1,  'h1,  1, 'h1,  'h1,  1, 4, 0, 2);
    step(20, 1, 'h0,  'h0,  'h0,  1, 'h0,  'h0,  0, 4, 0, 2);
    step(21, 1, 'h0,  'h0,  'h0,  0, 'h0,  'h0,  0, 4, 0, 3);
    step(22, 1, 'h1,  'h0,  'h1,  0, 'h1,  'h1,  1, 4, 0, 3);
    step(23, 0, 'h1,  'h0,  'h0,  0, 'h0,  'h0,  0, 3, 1, 3);
    step(24, 1, 'h3,  'h3,  'h3,  0, 'h3,  'h0,  0, 4, 0, 0);
    step(25, 1, 'h3,  'h3,  'h0,  0, 'h3,  'h0,  0, 4, 0, 2);
    step(26, 0, 'h0,  'h0,  'h0,  0, 'h0,  'h0,  0, 4, 0, 2);
    step(27, 1, 'h40, 'h40, 'h40, 0, 'h0,  'h0,  0, 4, 0, 0);
    step(28, 1, 'h0,  'h0,  'h0,  0, 'h0,  'h0,  0, 4, 0, 2);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
